// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter_if
// Brief    : Requester and CORDIC-engine signal bundle for cordic_arbiter.
// Revision : 1.0
// ============================================================================
interface cordic_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [24*NUM_REQ-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [23:0]           rsp_sin;
    logic [23:0]           rsp_cos;
    logic                  rsp_err;
    logic                  cordic_start;
    logic [23:0]           cordic_angle;
    logic                  cordic_reset;
    logic                  cordic_ready;
    logic [23:0]           cordic_sin;
    logic [23:0]           cordic_cos;

    // Arbiter side
    modport slave (
        input  req_valid, req_angle, cordic_ready, cordic_sin, cordic_cos,
        output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err,
               cordic_start, cordic_angle, cordic_reset
    );

    // Requesters plus engine side
    modport master (
        output req_valid, req_angle, cordic_ready, cordic_sin, cordic_cos,
        input  req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err,
               cordic_start, cordic_angle, cordic_reset
    );
endinterface
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter
// Brief    : Round-robin sharing of one CORDIC engine with range reduction.
// Revision : 1.0
// ============================================================================
module cordic_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 40
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    cordic_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic signed [23:0] C_PI      = 24'sh03243F;
    localparam logic signed [23:0] C_HALF_PI = 24'sh01921F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_req_ready;
    logic signed [23:0] w_angle;
    logic signed [23:0] w_reduced;
    logic               w_oor;
    logic               w_neg;
    logic               r_neg_cos;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_timeout;
    logic               r_wd_pulse;
    logic [23:0]        r_cordic_angle;
    logic [ID_W-1:0]    r_rsp_id;
    logic [23:0]        r_rsp_sin;
    logic [23:0]        r_rsp_cos;
    logic               r_rsp_err;

    // Descending scan so the lowest offset from r_ptr is the last to assign.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_win   = r_ptr;
        w_any   = 1'b0;
        w_angle = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                w_win   = ID_W'(idx);
                w_any   = 1'b1;
                w_angle = bus.req_angle[idx*24 +: 24];
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_any;

    always_comb begin : p_ready
        w_req_ready        = '0;
        w_req_ready[w_win] = w_grant && reset_n;
    end

    // Fold |a| in (pi/2, pi] back into [-pi/2, pi/2]; sin keeps its sign, cos flips.
    always_comb begin : p_reduce
        w_oor     = (w_angle > C_PI) || (w_angle < -C_PI);
        w_reduced = w_angle;
        w_neg     = 1'b0;
        if (w_angle > C_HALF_PI) begin
            w_reduced = C_PI - w_angle;
            w_neg     = 1'b1;
        end else if (w_angle < -C_HALF_PI) begin
            w_reduced = -C_PI - w_angle;
            w_neg     = 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin : p_state
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin : p_next
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = w_oor ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.cordic_ready || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Response fields only change on entry to RESP so they hold between strobes.
    always_ff @(posedge clk or negedge reset_n) begin : p_data
        if (!reset_n) begin
            r_ptr          <= '0;
            r_id           <= '0;
            r_neg_cos      <= 1'b0;
            r_cnt          <= '0;
            r_wd_pulse     <= 1'b0;
            r_cordic_angle <= '0;
            r_rsp_id       <= '0;
            r_rsp_sin      <= '0;
            r_rsp_cos      <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_wd_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id      <= w_win;
                        r_neg_cos <= w_neg;
                        if (w_oor) begin
                            r_rsp_id  <= w_win;
                            r_rsp_err <= 1'b1;
                            r_rsp_sin <= '0;
                            r_rsp_cos <= '0;
                        end else begin
                            r_cordic_angle <= w_reduced;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.cordic_ready) begin
                        r_rsp_id  <= r_id;
                        r_rsp_err <= 1'b0;
                        r_rsp_sin <= bus.cordic_sin;
                        r_rsp_cos <= r_neg_cos ? (~bus.cordic_cos + 24'd1) : bus.cordic_cos;
                    end else if (w_timeout) begin
                        r_wd_pulse <= 1'b1;
                        r_rsp_id   <= r_id;
                        r_rsp_err  <= 1'b1;
                        r_rsp_sin  <= '0;
                        r_rsp_cos  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = (r_state == S_RESP);
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_sin      = r_rsp_sin;
    assign bus.rsp_cos      = r_rsp_cos;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.cordic_start = (r_state == S_ISSUE);
    assign bus.cordic_angle = r_cordic_angle;
    assign bus.cordic_reset = ~reset_n | r_wd_pulse;

endmodule
`default_nettype wire

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one `cordic_sin_cos` engine among `NUM_REQ` requesters. It arbitrates requests round-robin and range-reduces each angle into the engine's convergence range. It sequences the engine's start/ready handshake and returns sin/cos tagged with the requester id. It also recovers the engine with a watchdog if `cordic_ready` never arrives. It sits between the angle-producing blocks and the single CORDIC instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 40: maximum cycles spent in WAIT before abort.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request pending, per requester; held until accepted.
- `req_angle`  in  24*NUM_REQ  Q8.16 signed angle, radians; slice k = bits [24k+23:24k].
- `req_ready`  out  NUM_REQ  accept strobe, combinational; at most one bit high.
- `rsp_valid`  out  1  one-cycle response strobe; there is no backpressure.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester being answered.
- `rsp_sin`, `rsp_cos`  out  24 each  Q8.16 results.
- `rsp_err`  out  1  set when the angle is out of range or the watchdog fired.
- `cordic_start`  out  1  start pulse to the engine.
- `cordic_angle`  out  24  reduced angle to the engine.
- `cordic_reset`  out  1  active-high synchronous reset to the engine.
- `cordic_ready`, `cordic_sin`, `cordic_cos`  in  1/24/24  outputs from the engine.

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - The winner is the first k with `req_valid[k]`, searching from `ptr` upward and wrapping.
  - `req_ready[winner]` is high this cycle.
  - Latch the id and the raw angle a.
  - Go to ISSUE, or to RESP with the error flag set if |a| > π (0x3243F). An out-of-range request never touches the engine.
- **Range reduction**, computed at latch time and registered:
  - a > π/2 (0x1921F): reduced = 0x3243F − a, `neg_cos` = 1.
  - a < −π/2: reduced = −0x3243F − a, `neg_cos` = 1.
  - Otherwise reduced = a, `neg_cos` = 0.
  - Exactly ±π/2 is not reduced.
- **ISSUE**: `cordic_start` = 1 and `cordic_angle` = reduced, for exactly one cycle. Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - On `cordic_ready`: capture `rsp_sin` = `cordic_sin` and `rsp_cos` = `neg_cos` ? −`cordic_cos` : `cordic_cos`, using 24-bit two's-complement negation that wraps. Go to RESP.
  - If the counter reaches TIMEOUT first: pulse `cordic_reset` for one cycle, set `rsp_err`, set sin = cos = 0, go to RESP.
  - A `cordic_ready` arriving in the same cycle as the timeout wins; no error is reported.
- **RESP**: `rsp_valid` = 1 for one cycle. `ptr` ← winner+1, wrapping at NUM_REQ. Go to IDLE.
- `cordic_ready` outside WAIT is ignored.
- `cordic_angle` holds its last value outside ISSUE.
- Error responses carry sin = cos = 0.

## Timing
- **Reset**:
  - Asserting `reset_n` low immediately sets state = IDLE and `ptr` = 0.
  - It clears the counter and all registered outputs: `rsp_*`, `cordic_start`, `cordic_angle` = 0.
  - `cordic_reset` = ~`reset_n` OR the watchdog pulse, so the engine is held in reset while `reset_n` is low.
  - An in-flight request is dropped silently and the requester must re-request. `req_ready` is 0 during reset.
- **Accept** in cycle T (IDLE, handshake).
- **Normal path**:
  - `cordic_start` is high in T+1.
  - `rsp_valid` is high in the cycle after `cordic_ready` is sampled high. With the 16-iteration engine this is T+21.
- **Out-of-range path**: `rsp_valid` in T+1.
- **Throughput**: the next accept happens in the cycle after RESP, so there is one idle cycle between a response and the next request.
- `rsp_*` fields are valid only while `rsp_valid` is high. They hold their values otherwise.
- **Simultaneous requests**: exactly one is granted per IDLE visit. The others keep `req_valid` high and wait.
- **Fairness**: a continuously requesting requester is served within NUM_REQ transactions.

## Test plan
- **Single request**: requester 0, angle 0x000000. Expect `rsp_valid` with id 0, `rsp_err` 0, sin ≈ 0, cos ≈ 0x010000 (±0x20), and latency T+21.
- **Reduction, upper side**: angle 0x020000 (2.0 rad). Expect `cordic_angle` = 0x01243F, `rsp_sin` ≈ 0x00E8C7, `rsp_cos` ≈ −0x006A88 (0xFF9578), both ±0x20.
- **Reduction, lower side**: angle −0x3243F. Expect `cordic_angle` = 0, sin ≈ 0, cos ≈ −0x010000.
- **Contention**, NUM_REQ = 4 and `ptr` = 0:
  - All requesters are valid in the same cycle. Expect ids 0, 1, 2, 3 in order.
  - Then requester 0 re-requests while 2 and 3 are already waiting with `ptr` = 2. Expect 2, 3, 0.
- **Out of range**: angle 0x040000. Expect `rsp_valid` at T+1 with `rsp_err` 1 and sin = cos = 0, `cordic_start` never pulsed, and `ptr` advanced.
- **Watchdog and reset**:
  - With `cordic_ready` tied low: expect `cordic_reset` pulsed, `rsp_err` 1, and `rsp_valid` at T+1+TIMEOUT+1.
  - Separately, pull `reset_n` low mid-WAIT: expect all outputs 0 at once, `cordic_reset` high while `reset_n` is low, no response, and the next accept granted to requester 0.
